axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/axi_rd_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-path constants, FSM state encoding and sizing helper.
// No logic; imported by the arbiter and its round-robin picker.
package axi_pkg;

  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 16;

  localparam int LEN_W   = 7;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [BURST_W-1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Index width that stays legal (>=1) even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after last+1 (mod N).
// Zero latency; no state and no backpressure of its own.
module rr_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_MST = 2,
  parameter int IDX_W   = idx_width(NUM_MST)
) (
  input  logic [NUM_MST-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_MST-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             found;
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MST; k++) begin
      cand = IDX_W'((int'(last_i) + k) % NUM_MST);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-to-1 AXI read arbiter, one burst in flight; AR reaches DRAM one cycle after grant.
// R beats flow combinationally to the granted master; its rready backpressures DRAM directly.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_MST    = 2,
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_MST*ID_WIDTH-1:0]      s_arid,
  input  logic [NUM_MST*ADDR_WIDTH-1:0]    s_araddr,
  input  logic [NUM_MST*LEN_W-1:0]         s_arlen,
  input  logic [NUM_MST*SIZE_W-1:0]        s_arsize,
  input  logic [NUM_MST*BURST_W-1:0]       s_arburst,
  input  logic [NUM_MST-1:0]               s_arvalid,
  output logic [NUM_MST-1:0]               s_arready,
  output logic [NUM_MST*ID_WIDTH-1:0]      s_rid,
  output logic [NUM_MST*DATA_WIDTH-1:0]    s_rdata,
  output logic [NUM_MST*RESP_W-1:0]        s_rresp,
  output logic [NUM_MST-1:0]               s_rlast,
  output logic [NUM_MST-1:0]               s_rvalid,
  input  logic [NUM_MST-1:0]               s_rready,
  output logic [ID_WIDTH-1:0]              m_arid,
  output logic [ADDR_WIDTH-1:0]            m_araddr,
  output logic [LEN_W-1:0]                 m_arlen,
  output logic [SIZE_W-1:0]                m_arsize,
  output logic [BURST_W-1:0]               m_arburst,
  output logic                             m_arvalid,
  input  logic                             m_arready,
  input  logic [ID_WIDTH-1:0]              m_rid,
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  input  logic [RESP_W-1:0]                m_rresp,
  input  logic                             m_rlast,
  input  logic                             m_rvalid,
  output logic                             m_rready,
  output logic                             busy,
  output logic                             prot_err
);

  localparam int IDX_W = idx_width(NUM_MST);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [IDX_W-1:0]        gnt_q, gnt_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [SIZE_W-1:0]       size_q, size_d;
  logic [BURST_W-1:0]      burst_q, burst_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic                    prot_q, prot_d;

  logic [NUM_MST-1:0]      arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_vld;
  logic                    arb_fire;
  logic                    route_en;
  logic                    r_hs;

  logic [ID_WIDTH-1:0]     ar_id    [NUM_MST];
  logic [ADDR_WIDTH-1:0]   ar_addr  [NUM_MST];
  logic [LEN_W-1:0]        ar_len   [NUM_MST];
  logic [SIZE_W-1:0]       ar_size  [NUM_MST];
  logic [BURST_W-1:0]      ar_burst [NUM_MST];

  rr_arbiter #(
    .NUM_MST (NUM_MST),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i  (s_arvalid),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .vld_o  (arb_vld)
  );

  for (genvar m = 0; m < NUM_MST; m++) begin : g_mst
    logic sel;
    assign sel = route_en && (gnt_q == IDX_W'(m));

    assign ar_id[m]    = s_arid[m*ID_WIDTH +: ID_WIDTH];
    assign ar_addr[m]  = s_araddr[m*ADDR_WIDTH +: ADDR_WIDTH];
    assign ar_len[m]   = s_arlen[m*LEN_W +: LEN_W];
    assign ar_size[m]  = s_arsize[m*SIZE_W +: SIZE_W];
    assign ar_burst[m] = s_arburst[m*BURST_W +: BURST_W];

    assign s_arready[m] = arb_fire && arb_gnt[m];

    // Non-selected slices are zeroed so idle masters never see stale beats.
    assign s_rvalid[m]                         = sel && m_rvalid;
    assign s_rlast[m]                          = sel && m_rlast;
    assign s_rid[m*ID_WIDTH +: ID_WIDTH]       = sel ? m_rid   : '0;
    assign s_rdata[m*DATA_WIDTH +: DATA_WIDTH] = sel ? m_rdata : '0;
    assign s_rresp[m*RESP_W +: RESP_W]         = sel ? m_rresp : '0;
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    prot_d    = prot_q;
    arb_fire  = 1'b0;
    route_en  = 1'b0;
    r_hs      = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        arb_fire = arb_vld;
        if (arb_vld) begin
          gnt_d   = arb_idx;
          id_d    = ar_id[arb_idx];
          addr_d  = ar_addr[arb_idx];
          len_d   = ar_len[arb_idx];
          size_d  = ar_size[arb_idx];
          burst_d = ar_burst[arb_idx];
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          cnt_d   = len_q;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        route_en = 1'b1;
        m_rready = s_rready[gnt_q];
        r_hs     = m_rvalid && m_rready;
        if (r_hs) begin
          cnt_d = cnt_q - 1'b1;
          // rlast must coincide exactly with the final counted beat.
          if (m_rlast != (cnt_q == '0)) begin
            prot_d = 1'b1;
          end
          if (m_rlast) begin
            last_d  = gnt_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // While reset is asserted nothing is granted or routed, even combinationally.
    if (!rst_n) begin
      arb_fire  = 1'b0;
      route_en  = 1'b0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= IDX_W'(NUM_MST - 1);
      gnt_q   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      prot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      prot_q  <= prot_d;
    end
  end

  assign m_arid    = id_q;
  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arsize  = size_q;
  assign m_arburst = burst_q;
  assign prot_err  = prot_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: table vectors, directed corner sequences,
// and randomized bursts scored against a transaction-level model.
module tb_axi_rd_arbiter;
  import axi_pkg::*;

  localparam int N  = 2;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*IW-1:0]   s_arid;
  logic [N*AW-1:0]   s_araddr;
  logic [N*7-1:0]    s_arlen;
  logic [N*3-1:0]    s_arsize;
  logic [N*2-1:0]    s_arburst;
  logic [N-1:0]      s_arvalid, s_arready;
  logic [N*IW-1:0]   s_rid;
  logic [N*DW-1:0]   s_rdata;
  logic [N*2-1:0]    s_rresp;
  logic [N-1:0]      s_rlast, s_rvalid, s_rready;
  logic [IW-1:0]     m_arid;
  logic [AW-1:0]     m_araddr;
  logic [6:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arvalid, m_arready;
  logic [IW-1:0]     m_rid;
  logic [DW-1:0]     m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast, m_rvalid, m_rready;
  logic              busy, prot_err;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.NUM_MST(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .prot_err(prot_err)
  );

  // Per-master request fields presented on the flattened AR ports.
  logic [IW-1:0] t_id    [N];
  logic [AW-1:0] t_addr  [N];
  logic [6:0]    t_len   [N];
  logic [2:0]    t_size  [N];
  logic [1:0]    t_burst [N];

  int checks = 0;
  int errors = 0;
  int model_last;
  bit exp_prot;

  typedef struct {
    logic [1:0]  mask;
    logic [6:0]  len;
    logic [31:0] addr;
    int          exp_g;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_ar();
    for (int i = 0; i < N; i++) begin
      s_arid[i*IW +: IW]  = t_id[i];
      s_araddr[i*AW +: AW] = t_addr[i];
      s_arlen[i*7 +: 7]    = t_len[i];
      s_arsize[i*3 +: 3]   = t_size[i];
      s_arburst[i*2 +: 2]  = t_burst[i];
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    s_arvalid = 2'b11;
    s_rready  = '0;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", s_arready, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_prot_err", prot_err, 0);
    chk("rst_s_rvalid", s_rvalid, 0);
    rst_n      = 1'b1;
    s_arvalid  = 2'b00;
    exp_prot   = 1'b0;
    model_last = N - 1;
  endtask

  task automatic ar_phase(input logic [1:0] mask, input int g, input bit hold);
    int w;
    drive_ar();
    s_arvalid = mask;
    #1;
    chk("gnt_arready", s_arready, 2'b01 << g);
    chk("gnt_m_arvalid_low", m_arvalid, 0);
    chk("gnt_busy_low", busy, 0);
    @(posedge clk);
    #1;
    s_arvalid = hold ? (mask & ~(2'b01 << g)) : 2'b00;
    #1;
    chk("ar_m_arvalid", m_arvalid, 1);
    chk("ar_addr", m_araddr, t_addr[g]);
    chk("ar_id", m_arid, t_id[g]);
    chk("ar_len", m_arlen, t_len[g]);
    chk("ar_size", m_arsize, t_size[g]);
    chk("ar_burst", m_arburst, t_burst[g]);
    chk("ar_arready_pulse", s_arready, 0);
    chk("ar_busy", busy, 1);
    w = $urandom_range(0, 2);
    repeat (w) begin
      @(posedge clk);
      #1;
      chk("ar_hold_valid", m_arvalid, 1);
      chk("ar_hold_addr", m_araddr, t_addr[g]);
    end
    m_arready = 1'b1;
    @(posedge clk);
    #1;
    m_arready = 1'b0;
  endtask

  task automatic data_phase(input int g, input int n_beats, input int stall_at, input bit rnd);
    int b = 0;
    int cyc = 0;
    int stalled = 0;
    bit rdy;
    while (b < n_beats && cyc < 1500) begin
      m_rvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_rdata  = DW'($urandom);
      m_rid    = t_id[g];
      m_rresp  = 2'($urandom);
      m_rlast  = (b == n_beats - 1);
      if (rnd) rdy = ($urandom_range(0, 2) != 0);
      else if (b == stall_at && stalled < 3) begin
        rdy = 1'b0;
        stalled++;
      end else rdy = 1'b1;
      s_rready    = 2'($urandom);
      s_rready[g] = rdy;
      #1;
      chk("r_valid_route", s_rvalid, m_rvalid ? (2'b01 << g) : 2'b00);
      chk("r_ready_pass", m_rready, rdy);
      chk("r_arready_low", s_arready, 0);
      chk("r_busy", busy, 1);
      if (m_rvalid && rdy) begin
        chk("r_data", s_rdata[g*DW +: DW], m_rdata);
        chk("r_id", s_rid[g*IW +: IW], t_id[g]);
        chk("r_resp", s_rresp[g*2 +: 2], m_rresp);
        chk("r_last", s_rlast[g], m_rlast);
        b++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = '0;
    if (b < n_beats) chk("r_timeout_beats", b, n_beats);
  endtask

  // The model treats a burst as one transaction: a protocol error is any
  // burst whose delivered beat count differs from arlen+1.
  task automatic do_txn(input logic [1:0] mask, input int g, input int n_beats,
                        input bit hold, input int stall_at, input bit rnd);
    ar_phase(mask, g, hold);
    data_phase(g, n_beats, stall_at, rnd);
    #1;
    chk("done_busy", busy, 0);
    if (n_beats != int'(t_len[g]) + 1) exp_prot = 1'b1;
    chk("done_prot_err", prot_err, exp_prot);
    model_last = g;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    logic [1:0] mask;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    m_rid = '0; m_rdata = '0; m_rresp = '0;
    for (int i = 0; i < N; i++) begin
      t_id[i]    = IW'(i + 3);
      t_addr[i]  = 32'h2000 + 32'(i * 'h40);
      t_len[i]   = 7'd1;
      t_size[i]  = 3'd1;
      t_burst[i] = BURST_INCR;
    end

    // Table: {mask, arlen, base address, expected grant}, starting from last_grant=1.
    vecs[0] = '{2'b11, 7'd0,   32'h0000_0100, 0};
    vecs[1] = '{2'b11, 7'd7,   32'h0000_0200, 1};
    vecs[2] = '{2'b11, 7'd127, 32'h0000_0300, 0};
    vecs[3] = '{2'b10, 7'd3,   32'h0000_0400, 1};
    vecs[4] = '{2'b10, 7'd0,   32'h0000_0500, 1};
    vecs[5] = '{2'b01, 7'd1,   32'h0000_0600, 0};
    vecs[6] = '{2'b01, 7'd15,  32'h0000_0700, 0};
    vecs[7] = '{2'b11, 7'd2,   32'h0000_0800, 1};

    do_reset();

    // Both request together: master 0 first, master 1 immediately after rlast.
    t_len[0] = 7'd2;
    t_len[1] = 7'd1;
    do_txn(2'b11, 0, 3, 1'b1, -1, 1'b0);
    do_txn(2'b10, 1, 2, 1'b0, -1, 1'b0);

    // Lone master 1, 8-beat burst at 0x1000 with a 3-cycle stall on beat 3.
    t_addr[1] = 32'h0000_1000;
    t_len[1]  = 7'd7;
    t_id[1]   = 4'hA;
    do_txn(2'b10, 1, 8, 1'b0, 3, 1'b0);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) begin
        t_addr[i] = vecs[v].addr + 32'(i * 'h100);
        t_len[i]  = vecs[v].len;
        t_id[i]   = IW'(v + i);
      end
      do_txn(vecs[v].mask, vecs[v].exp_g, int'(vecs[v].len) + 1, 1'b0, -1, v[0]);
    end

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        t_id[i]   = IW'($urandom);
        t_addr[i] = $urandom;
        t_len[i]  = ($urandom_range(0, 9) == 0) ? 7'd127 : 7'($urandom_range(0, 12));
        t_size[i] = 3'($urandom_range(0, 1));
      end
      mask = 2'($urandom_range(1, 3));
      g = model_grant(mask, model_last);
      do_txn(mask, g, int'(t_len[g]) + 1, 1'b0, -1, 1'b1);
    end

    // Early rlast: arlen=3 but DRAM ends after 3 beats; flag sticks until reset.
    do_reset();
    t_len[0] = 7'd3;
    do_txn(2'b01, 0, 3, 1'b0, -1, 1'b0);
    t_len[1] = 7'd1;
    g = model_grant(2'b11, model_last);
    do_txn(2'b11, g, 2, 1'b0, -1, 1'b0);
    chk("prot_sticky", prot_err, 1);
    do_reset();

    // Reset during beat 4 of a 16-beat burst: nothing routed afterwards.
    t_len[0] = 7'd15;
    ar_phase(2'b01, 0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = DW'($urandom);
      m_rlast  = 1'b0;
      s_rready = 2'b11;
      #1;
      chk("mid_pre_route", s_rvalid, 2'b01);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      m_rvalid = 1'b1;
      m_rdata  = DW'($urandom);
      #1;
      chk("mid_rst_rvalid", s_rvalid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_m_rready", m_rready, 0);
      @(posedge clk);
      #1;
    end
    m_rvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
